// File: rtl/jbi_min_arb_track_pkg.sv
// Shared JBus receive-side definitions: J_ADTYPE codes, arb-mode encodings,
// agent indices and the registered packet-flag bundle.
package jbi_min_arb_track_pkg;

    // J_ADTYPE codes
    localparam logic [7:0] ADTYPE_IDLE      = 8'h00;
    localparam int         ADTYPE_KIND_HI   = 7;
    localparam int         ADTYPE_KIND_LO   = 6;
    localparam logic [1:0] ADTYPE_KIND_HDR  = 2'b10;
    localparam logic [1:0] ADTYPE_KIND_DATA = 2'b01;

    // Agent indices on the request vector
    localparam int AGENT_JBI  = 0;
    localparam int AGENT_REQ4 = 1;
    localparam int AGENT_REQ5 = 2;

    // CSR arbitration mode; 2'b11 behaves like ARB_DEAD_SAMPLE
    typedef enum logic [1:0] {
        ARB_DEAD_SAMPLE   = 2'b00,
        ARB_DEAD_NOSAMPLE = 2'b01,
        ARB_NO_DEAD       = 2'b10,
        ARB_RSVD          = 2'b11
    } arb_mode_e;

    // Registered per-cycle framing/error pulses
    typedef struct packed {
        logic start;
        logic data;
        logic last;
        logic abort;
        logic err_sw;
        logic err_hdr;
    } pkt_flags_t;

    function automatic logic adtype_is_hdr(input logic [7:0] a);
        return a[ADTYPE_KIND_HI:ADTYPE_KIND_LO] == ADTYPE_KIND_HDR;
    endfunction

    function automatic logic adtype_is_data(input logic [7:0] a);
        return a[ADTYPE_KIND_HI:ADTYPE_KIND_LO] == ADTYPE_KIND_DATA;
    endfunction

endpackage

// File: rtl/jbi_min_arb_track_if.sv
// Bus bundle for the JBus ownership tracker: sampled JBus/CSR inputs and
// owner/framing outputs.
interface jbi_min_arb_track_if #(
    parameter int NUM_AGENTS = 3
);
    logic [NUM_AGENTS-1:0] io_jbi_j_req_in_l;
    logic [1:0]            csr_jbi_config_arb_mode;
    logic [7:0]            io_jbi_j_adtype;

    logic [NUM_AGENTS-1:0] min_owner_oh;
    logic [2:0]            min_owner_id;
    logic                  min_bus_switch;
    logic                  min_dsbl_sampling;
    logic                  min_own_cycle;
    logic                  min_pkt_start;
    logic                  min_pkt_data;
    logic                  min_pkt_end;
    logic                  min_pkt_abort;
    logic                  min_err_owner_switch;
    logic                  min_err_unexp_hdr;

    modport master (
        output io_jbi_j_req_in_l, csr_jbi_config_arb_mode, io_jbi_j_adtype,
        input  min_owner_oh, min_owner_id, min_bus_switch, min_dsbl_sampling,
               min_own_cycle, min_pkt_start, min_pkt_data, min_pkt_end,
               min_pkt_abort, min_err_owner_switch, min_err_unexp_hdr
    );

    modport slave (
        input  io_jbi_j_req_in_l, csr_jbi_config_arb_mode, io_jbi_j_adtype,
        output min_owner_oh, min_owner_id, min_bus_switch, min_dsbl_sampling,
               min_own_cycle, min_pkt_start, min_pkt_data, min_pkt_end,
               min_pkt_abort, min_err_owner_switch, min_err_unexp_hdr
    );
endinterface

// File: rtl/jbi_min_arb_track_rr.sv
// Combinational JBus round-robin next-owner calculation. The owner keeps the
// bus while requesting; otherwise the grant goes to the first requester found
// scanning downward from owner-1 with wrap. With no requester the owner parks.
module jbi_rr_next_owner #(
    parameter int NUM_AGENTS = 3
) (
    input  logic [NUM_AGENTS-1:0] req,
    input  logic [NUM_AGENTS-1:0] owner,
    output logic [NUM_AGENTS-1:0] owner_nxt
);

    // Pick the requester with the smallest nonzero downward distance from owner
    always_comb begin
        int own_idx;
        int best_j;
        int best_d;
        int d;
        own_idx = 0;
        for (int j = 0; j < NUM_AGENTS; j++)
            if (owner[j]) own_idx = j;
        best_j = 0;
        best_d = NUM_AGENTS;
        for (int j = 0; j < NUM_AGENTS; j++) begin
            d = (own_idx - j + NUM_AGENTS) % NUM_AGENTS;
            if (req[j] && d != 0 && d < best_d) begin
                best_d = d;
                best_j = j;
            end
        end
        owner_nxt = owner;
        if (!(|(req & owner)) && best_d < NUM_AGENTS)
            owner_nxt = {{(NUM_AGENTS-1){1'b0}}, 1'b1} << best_j;
    end

endmodule

// File: rtl/jbi_min_arb_track.sv
// Receive-side JBus ownership tracker: replays round-robin arbitration from
// the sampled requests, applies the dead-cycle policy and frames packets
// driven by other agents, flagging mid-packet protocol violations.
module jbi_min_arb_track
    import jbi_min_arb_track_pkg::*;
#(
    parameter int NUM_AGENTS = 3,
    parameter int LEN_W      = 3
) (
    input  logic                clk,
    input  logic                rst,
    jbi_min_arb_track_if.slave  bus
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_DATA = 1'b1;

    logic [NUM_AGENTS-1:0] req;
    logic [NUM_AGENTS-1:0] owner_q;
    logic [NUM_AGENTS-1:0] owner_nxt;
    logic                  bus_switch;
    arb_mode_e             mode_q;
    logic                  dead_q;
    logic                  frame_en;
    logic [2:0]            owner_id;

    logic [0:0]            state_q, state_n;
    logic [LEN_W-1:0]      cnt_q, cnt_n;
    logic [LEN_W-1:0]      hdr_len;
    logic                  is_hdr, is_data;
    pkt_flags_t            flags_q, flags_n;

    assign req = ~bus.io_jbi_j_req_in_l;

    jbi_rr_next_owner #(.NUM_AGENTS(NUM_AGENTS)) u_rr (
        .req       (req),
        .owner     (owner_q),
        .owner_nxt (owner_nxt)
    );

    assign bus_switch = (owner_nxt != owner_q);

    // Owner register, registered arb mode and dead-cycle marker
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= {{(NUM_AGENTS-1){1'b0}}, 1'b1};
            mode_q  <= ARB_DEAD_SAMPLE;
            dead_q  <= 1'b0;
        end else begin
            owner_q <= owner_nxt;
            mode_q  <= arb_mode_e'(bus.csr_jbi_config_arb_mode);
            dead_q  <= bus_switch && (mode_q != ARB_NO_DEAD);
        end
    end

    // Binary encode of the owner presented this cycle
    always_comb begin
        owner_id = 3'd0;
        for (int j = 0; j < NUM_AGENTS; j++)
            if (owner_nxt[j]) owner_id = 3'(j);
    end

    // Only packets from other agents on live cycles are framed
    assign frame_en = !dead_q && !owner_nxt[AGENT_JBI];
    assign hdr_len  = bus.io_jbi_j_adtype[LEN_W-1:0];
    assign is_hdr   = adtype_is_hdr(bus.io_jbi_j_adtype);
    assign is_data  = adtype_is_data(bus.io_jbi_j_adtype);

    // Framing FSM; an owner switch mid-packet wins over any header/data
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        flags_n = '0;
        if (state_q == ST_DATA && bus_switch) begin
            flags_n.err_sw = 1'b1;
            flags_n.abort  = 1'b1;
            state_n        = ST_IDLE;
            cnt_n          = '0;
        end else if (frame_en) begin
            if (is_hdr) begin
                if (state_q == ST_DATA) begin
                    flags_n.err_hdr = 1'b1;
                    flags_n.abort   = 1'b1;
                end
                flags_n.start = 1'b1;
                if (hdr_len == '0) begin
                    flags_n.last = 1'b1;
                    state_n      = ST_IDLE;
                    cnt_n        = '0;
                end else begin
                    state_n = ST_DATA;
                    cnt_n   = hdr_len;
                end
            end else if (is_data && state_q == ST_DATA) begin
                flags_n.data = 1'b1;
                cnt_n        = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) begin
                    flags_n.last = 1'b1;
                    state_n      = ST_IDLE;
                end
            end
        end
    end

    // FSM state and registered framing pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            flags_q <= flags_n;
        end
    end

    assign bus.min_owner_oh         = owner_nxt;
    assign bus.min_owner_id         = owner_id;
    assign bus.min_bus_switch       = bus_switch;
    assign bus.min_dsbl_sampling    = dead_q && (mode_q == ARB_DEAD_NOSAMPLE);
    assign bus.min_own_cycle        = owner_nxt[AGENT_JBI] && !dead_q;
    assign bus.min_pkt_start        = flags_q.start;
    assign bus.min_pkt_data         = flags_q.data;
    assign bus.min_pkt_end          = flags_q.last;
    assign bus.min_pkt_abort        = flags_q.abort;
    assign bus.min_err_owner_switch = flags_q.err_sw;
    assign bus.min_err_unexp_hdr    = flags_q.err_hdr;

endmodule

// File: doc/jbi_min_arb_track.md
Name: jbi_min_arb_track

Overview:
Receive-side JBus ownership tracker for jbi_min, the observer counterpart of the distributed requester in jbi_mout.
- Replays the JBus round-robin arbitration from the sampled J_REQ lines to learn the current owner each cycle.
- Applies the CSR dead-cycle policy and frames incoming packets from J_ADTYPE.
- Flags protocol violations: owner change mid-packet, and header during data.

Parameters:
NUM_AGENTS, 3, number of arbitrating agents; index 0 is JBI, 1 is J_REQ4, 2 is J_REQ5; legal 2..6.
LEN_W, 3, width of the header data-length field.

Ports:
clk  input  1  clock.
rst  input  1  synchronous reset, active-high.
io_jbi_j_req_in_l  input  NUM_AGENTS  active-low requests, already aligned; bit 0 is our own request delayed 2 cycles.
csr_jbi_config_arb_mode  input  2  00 dead+sample, 01 dead+no-sample, 10 no dead, 11 treated as 00.
io_jbi_j_adtype  input  8  registered J_ADTYPE.
min_owner_oh  output  NUM_AGENTS  one-hot current owner.
min_owner_id  output  3  binary current owner.
min_bus_switch  output  1  owner changed this cycle.
min_dsbl_sampling  output  1  suppress capture of bidirs this cycle.
min_own_cycle  output  1  JBI owns bus and cycle is not dead.
min_pkt_start  output  1  header cycle accepted.
min_pkt_data  output  1  data cycle of a framed packet.
min_pkt_end  output  1  last cycle of packet.
min_pkt_abort  output  1  packet terminated early.
min_err_owner_switch  output  1  one-cycle pulse; owner changed while in DATA.
min_err_unexp_hdr  output  1  one-cycle pulse; header seen while in DATA.

Behaviour:
- req[i] = ~io_jbi_j_req_in_l[i]. The arb mode is registered once before use.
- Owner register (one-hot):
  - Reset value 1 at bit 0; all other outputs reset to 0.
  - Hold when no non-owner is requesting (park).
  - Owner keeps the grant while it requests.
  - When the owner drops its request and another agent requests, the next owner is the first requester scanning downward from owner-1 with wrap (0 -> N-1 -> ... -> 1). This must match the jbi_mout grant ordering exactly.
- min_bus_switch = next owner differs from current owner. The owner outputs reflect the updated owner in the same cycle as min_bus_switch.
- Dead cycle: in modes 00/01/11, the cycle after min_bus_switch is dead.
  - A dead cycle is not framed and min_own_cycle=0.
  - min_dsbl_sampling=1 on a dead cycle only in mode 01.
  - Mode 10 has no dead cycles.
- Framing applies only on non-dead cycles with owner != 0.
- Codes come from the jbi.h defines:
  - ADTYPE_IDLE, 8'h00.
  - Header when adtype[7:6]=2'b10, with length = adtype[LEN_W-1:0].
  - Data when adtype[7:6]=2'b01.
- Framing FSM, states IDLE and DATA, with a down-counter cnt:
  - IDLE + header, len=0: pkt_start and pkt_end in the same cycle; stay IDLE.
  - IDLE + header, len>0: pkt_start; cnt=len; go to DATA.
  - IDLE + data: ignored, no error.
  - DATA + data: pkt_data, cnt-1. If cnt==1: pkt_end and go to IDLE.
  - DATA + idle: stall; cnt unchanged.
  - DATA + header: err_unexp_hdr and pkt_abort for the old packet. The new packet starts in the same cycle (pkt_start; cnt reloads, or pkt_end if len=0).
  - DATA + min_bus_switch: err_owner_switch and pkt_abort; go to IDLE. The switch has priority over any simultaneous data/header.
  - Dead cycles in DATA (possible only after a switch) are already handled by the abort.
- All pkt_* and err_* outputs are registered: 1 cycle latency from io_jbi_j_adtype.
- min_owner_* and min_dsbl_sampling are combinational from the next-owner calculation, aligned with jbi_mout grant timing.
- rst asserted mid-packet: FSM to IDLE, cnt 0, no abort or error pulse; owner returns to bit 0.

Decomposition:
- jbi.h defines: ADTYPE codes, header/data field positions, arb-mode encodings, agent index constants (JBI=0, REQ4=1, REQ5=2).
- One sub-module, jbi_rr_next_owner: combinational next-owner calculation shared with a future rewrite of jbi_mout arbitration. The owner register, dead-cycle logic and FSM stay in the top level.

Test Plan:
- Reset, then req=3'b000 -> owner_oh=001, no switch; rst pulsed mid-DATA -> IDLE and no err pulse.
- req 3'b110 with owner 0 (not requesting) -> next owner 2. Then drop req[2] with req[1] up -> owner 1, switch=1, one dead cycle. Mode 01 -> dsbl_sampling=1 for exactly that cycle; mode 10 -> 0 dead cycles.
- Owner 1, header len=3 then data, idle, data, data -> pkt_start, then pkt_data x3 with one-cycle stall, pkt_end on the 3rd data cycle.
- Owner 2 in DATA cnt=2, req[2] drops while req[1] is up -> err_owner_switch=1, pkt_abort=1 for 1 cycle, FSM IDLE.
- DATA cnt=2, header len=0 arrives -> err_unexp_hdr, pkt_abort, and pkt_start+pkt_end in the same cycle.
- Owner 0 with header adtype -> no pkt_start; min_own_cycle=1 except on dead cycles.
